// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA display path: default 640x480@60 porch/sync
// values, frame totals, coordinate width and sync polarity.
package vga_timing_pkg;

   localparam int COORD_W = 10;
   typedef logic [COORD_W-1:0] coord_t;

   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   localparam logic SYNC_ACTIVE = 1'b0;

   // Sync output level for a coordinate: active inside [first, last], idle elsewhere.
   function automatic logic sync_level(coord_t pos, coord_t first, coord_t last);
      return ((pos >= first) && (pos <= last)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from vga_sync_gen to the painters and the VGA connector.
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   logic   pixel_tick;
   coord_t pix_x;
   coord_t pix_y;
   logic   video_on;
   logic   hsync;
   logic   vsync;
   logic   line_tick;
   logic   frame_tick;
   logic   sec_tick;

   modport master (
      output pixel_tick, pix_x, pix_y, video_on, hsync, vsync,
             line_tick, frame_tick, sec_tick
   );

   modport slave (
      input  pixel_tick, pix_x, pix_y, video_on, hsync, vsync,
             line_tick, frame_tick, sec_tick
   );

endinterface

// File: rtl/vga_tick_div.sv
// Pixel-enable divider: div_cnt sweeps 0..TICK_DIV-1, pixel_tick marks the last count.
module vga_tick_div #(
   parameter int TICK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   output logic pixel_tick
);

   // A 1-bit counter parked at 0 keeps TICK_DIV=1 on the same path (tick always high).
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign pixel_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing source: H/V counters, registered sync, line/frame/second strobes.
// Optional VGA_SYNC_SEC_TICK_EN builds the frame counter behind sec_tick.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_DISPLAY      = H_DISPLAY_DEF,
   parameter int H_FRONT        = H_FRONT_DEF,
   parameter int H_SYNC         = H_SYNC_DEF,
   parameter int H_BACK         = H_BACK_DEF,
   parameter int V_DISPLAY      = V_DISPLAY_DEF,
   parameter int V_FRONT        = V_FRONT_DEF,
   parameter int V_SYNC         = V_SYNC_DEF,
   parameter int V_BACK         = V_BACK_DEF,
   parameter int TICK_DIV       = 2,
   parameter int FRAMES_PER_SEC = 60
) (
   input  logic           clk,
   input  logic           reset_n,
   vga_sync_gen_if.master vga
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
   localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
   localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
   localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
   localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 || TICK_DIV < 1 ||
          FRAMES_PER_SEC < 1 || FRAMES_PER_SEC > 64) begin : g_bad_cfg
         $error("vga_sync_gen: illegal timing parameters");
      end
   endgenerate

   logic   pixel_tick;
   coord_t x_q, y_q;
   coord_t x_nxt, y_nxt;
   logic   hsync_q, vsync_q;
   logic   line_tick, frame_tick;

   vga_tick_div #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_div (
      .clk        (clk),
      .reset_n    (reset_n),
      .pixel_tick (pixel_tick)
   );

   always_comb begin
      x_nxt = x_q;
      y_nxt = y_q;
      if (pixel_tick) begin
         if (x_q == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y_q == V_LAST) ? '0 : y_q + 1'b1;
         end else begin
            x_nxt = x_q + 1'b1;
         end
      end
   end

   // Sync is registered from the next coordinates so it flips on the same edge as pix_x/pix_y.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q     <= '0;
         y_q     <= '0;
         hsync_q <= ~SYNC_ACTIVE;
         vsync_q <= ~SYNC_ACTIVE;
      end else begin
         x_q     <= x_nxt;
         y_q     <= y_nxt;
         hsync_q <= sync_level(x_nxt, HS_FIRST, HS_LAST);
         vsync_q <= sync_level(y_nxt, VS_FIRST, VS_LAST);
      end
   end

   assign line_tick  = pixel_tick && (x_q == H_LAST);
   assign frame_tick = line_tick && (y_q == V_LAST);

   assign vga.pixel_tick = pixel_tick;
   assign vga.pix_x      = x_q;
   assign vga.pix_y      = y_q;
   assign vga.video_on   = (x_q < H_VIS) && (y_q < V_VIS);
   assign vga.hsync      = hsync_q;
   assign vga.vsync      = vsync_q;
   assign vga.line_tick  = line_tick;
   assign vga.frame_tick = frame_tick;

`ifdef VGA_SYNC_SEC_TICK_EN
   localparam logic [5:0] SEC_LAST = 6'(FRAMES_PER_SEC - 1);

   logic [5:0] frame_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
      end else if (frame_tick) begin
         frame_cnt <= (frame_cnt == SEC_LAST) ? '0 : frame_cnt + 1'b1;
      end
   end

   assign vga.sec_tick = frame_tick && (frame_cnt == SEC_LAST);
`else
   assign vga.sec_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: three instances against a cycle-count raster model,
// with asynchronous resets dropped at random points.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // Instance A: shrunk raster, TICK_DIV=2
   localparam int A_HD = 16, A_HF = 4, A_HS = 6, A_HB = 4;
   localparam int A_VD = 8,  A_VF = 2, A_VS = 2, A_VB = 3;
   localparam int A_DIV = 2, A_FPS = 4;
   // Instance B: shrunk raster, TICK_DIV=1
   localparam int B_HD = 10, B_HF = 2, B_HS = 3, B_HB = 2;
   localparam int B_VD = 6,  B_VF = 1, B_VS = 2, B_VB = 2;
   localparam int B_DIV = 1, B_FPS = 3;
   // Instance C: default 640x480 timing
   localparam int C_HD = 640, C_HF = 16, C_HS = 96, C_HB = 48;
   localparam int C_VD = 480, C_VF = 10, C_VS = 2,  C_VB = 33;
   localparam int C_DIV = 2, C_FPS = 60;

   vga_sync_gen_if if_a ();
   vga_sync_gen_if if_b ();
   vga_sync_gen_if if_c ();

   vga_sync_gen #(
      .H_DISPLAY (A_HD), .H_FRONT (A_HF), .H_SYNC (A_HS), .H_BACK (A_HB),
      .V_DISPLAY (A_VD), .V_FRONT (A_VF), .V_SYNC (A_VS), .V_BACK (A_VB),
      .TICK_DIV (A_DIV), .FRAMES_PER_SEC (A_FPS)
   ) dut_a (.clk (clk), .reset_n (reset_n), .vga (if_a));

   vga_sync_gen #(
      .H_DISPLAY (B_HD), .H_FRONT (B_HF), .H_SYNC (B_HS), .H_BACK (B_HB),
      .V_DISPLAY (B_VD), .V_FRONT (B_VF), .V_SYNC (B_VS), .V_BACK (B_VB),
      .TICK_DIV (B_DIV), .FRAMES_PER_SEC (B_FPS)
   ) dut_b (.clk (clk), .reset_n (reset_n), .vga (if_b));

   vga_sync_gen #(
      .H_DISPLAY (C_HD), .H_FRONT (C_HF), .H_SYNC (C_HS), .H_BACK (C_HB),
      .V_DISPLAY (C_VD), .V_FRONT (C_VF), .V_SYNC (C_VS), .V_BACK (C_VB),
      .TICK_DIV (C_DIV), .FRAMES_PER_SEC (C_FPS)
   ) dut_c (.clk (clk), .reset_n (reset_n), .vga (if_c));

   // {pixel_tick, pix_x, pix_y, video_on, hsync, vsync, line_tick, frame_tick, sec_tick}
   logic [26:0] obs_a, obs_b, obs_c;
   assign obs_a = {if_a.pixel_tick, if_a.pix_x, if_a.pix_y, if_a.video_on, if_a.hsync,
                   if_a.vsync, if_a.line_tick, if_a.frame_tick, if_a.sec_tick};
   assign obs_b = {if_b.pixel_tick, if_b.pix_x, if_b.pix_y, if_b.video_on, if_b.hsync,
                   if_b.vsync, if_b.line_tick, if_b.frame_tick, if_b.sec_tick};
   assign obs_c = {if_c.pixel_tick, if_c.pix_x, if_c.pix_y, if_c.video_on, if_c.hsync,
                   if_c.vsync, if_c.line_tick, if_c.frame_tick, if_c.sec_tick};

   int checks = 0;
   int errors = 0;
   int n = 0;

   task automatic check_val(input string tag, input logic [26:0] got, input logic [26:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
      end
   endtask

   // Outputs after n clk edges since reset release, derived from the count of pixel ticks.
   function automatic logic [26:0] ref_out(int cyc, int hd, int hf, int hs, int hb,
                                           int vd, int vf, int vs, int vb, int div, int fps);
      int   ht    = hd + hf + hs + hb;
      int   vt    = vd + vf + vs + vb;
      int   ticks = cyc / div;
      int   p     = ticks % (ht * vt);
      int   fidx  = ticks / (ht * vt);
      int   x     = p % ht;
      int   y     = p / ht;
      logic pt    = (cyc % div) == (div - 1);
      logic lt    = pt && (x == ht - 1);
      logic ft    = lt && (y == vt - 1);
      logic st    = 1'b0;
      logic von   = (x < hd) && (y < vd);
      logic hsy   = !((x >= hd + hf) && (x < hd + hf + hs));
      logic vsy   = !((y >= vd + vf) && (y < vd + vf + vs));
      logic [9:0] xv = 10'(x);
      logic [9:0] yv = 10'(y);
`ifdef VGA_SYNC_SEC_TICK_EN
      st = ft && ((fidx % fps) == fps - 1);
`else
      st = 1'b0 && (fidx == fps);
`endif
      return {pt, xv, yv, von, hsy, vsy, lt, ft, st};
   endfunction

   task automatic check_all(input string phase);
      check_val({phase, "_a"}, obs_a,
                ref_out(n, A_HD, A_HF, A_HS, A_HB, A_VD, A_VF, A_VS, A_VB, A_DIV, A_FPS));
      check_val({phase, "_b"}, obs_b,
                ref_out(n, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB, B_DIV, B_FPS));
      check_val({phase, "_c"}, obs_c,
                ref_out(n, C_HD, C_HF, C_HS, C_HB, C_VD, C_VF, C_VS, C_VB, C_DIV, C_FPS));
   endtask

   initial begin
      int run_len;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      n = 0;
      for (int seg = 0; seg < 4 && errors < 30; seg++) begin
         run_len = (seg == 0) ? 4000 : int'($urandom_range(2500, 6000));
         for (int c = 0; c < run_len && errors < 30; c++) begin
            @(negedge clk);
            check_all("run");
            @(posedge clk);
            n++;
         end
         // Asynchronous reset mid-cycle: outputs must drop without waiting for an edge.
         @(posedge clk);
         #(1 + $urandom_range(0, 2));
         reset_n = 1'b0;
         n = 0;
         #1;
         check_all("async_rst");
         repeat (2) begin
            @(negedge clk);
            check_all("held_rst");
         end
         @(posedge clk);
         #2 reset_n = 1'b1;
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
